adc_sample_scheduler: RTL and testbench

Sequences the SPI ADC master by issuing conversion requests from a periodic timer or a manual request pulse, and handshakes on the master's start, busy and done signals. Captures each 8-bit result and produces a running block average over 2^AVG_LOG2 samples for the FND display path. Detects a stalled SPI master with a timeout. Sits between the SPI master and the display/LED logic.

---
 rtl/adc_sample_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// Schedules SPI ADC conversions from a periodic tick or a manual request,
// captures each result, block-averages 2^AVG_LOG2 samples and flags SPI stalls.
module adc_sample_scheduler #(
  parameter int PERIOD   = 50000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_en,
  input  logic              manual_req,
  output logic              spi_start,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic              timeout_err,
  output logic              req_drop
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_CAPTURE   = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [PCNT_W-1:0] pcnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  sum_s;
  logic [IDX_W-1:0]  idx_r;
  logic              pending_r;
  logic              tick_s;
  logic              new_req_s;
  logic              req_s;
  logic              capture_s;
  logic              abort_s;
  logic              to_clr_s;
  logic              to_expired_s;
  logic              spi_start_r;
  logic              sample_valid_r;
  logic [DATA_W-1:0] sample_data_r;
  logic              avg_valid_r;
  logic [DATA_W-1:0] avg_data_r;
  logic              timeout_err_r;
  logic              req_drop_r;

  assign tick_s       = auto_en && (pcnt_r == PCNT_LAST);
  assign new_req_s    = manual_req | tick_s;
  assign req_s        = new_req_s | pending_r;
  assign to_expired_s = (to_cnt_r == TO_LAST);
  assign sum_s        = acc_r + ACC_W'(spi_data);

  // Free-running period counter, parked at zero while auto conversions are off.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_r <= '0;
    end else if (!auto_en || (pcnt_r == PCNT_LAST)) begin
      pcnt_r <= '0;
    end else begin
      pcnt_r <= pcnt_r + 1'b1;
    end
  end

  // Next-state logic; progress on busy/done takes priority over the timeout.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    abort_s   = 1'b0;
    to_clr_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          state_s  = S_START;
          to_clr_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (spi_busy) begin
          state_s  = S_WAIT_DONE;
          to_clr_s = 1'b1;
        end else if (to_expired_s) begin
          state_s = S_WAIT_IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = S_START;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          state_s   = S_CAPTURE;
          capture_s = 1'b1;
        end else if (to_expired_s) begin
          state_s = S_WAIT_IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = S_WAIT_DONE;
        end
      end
      S_CAPTURE: begin
        state_s = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!spi_busy) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, timeout counter, one-deep request queue and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      to_cnt_r      <= '0;
      pending_r     <= 1'b0;
      spi_start_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      req_drop_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      spi_start_r <= (state_s == S_START);
      if (to_clr_s) begin
        to_cnt_r <= '0;
      end else if ((state_r == S_START) || (state_r == S_WAIT_DONE)) begin
        to_cnt_r <= to_cnt_r + 1'b1;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      // In IDLE any request (including a pending one) is consumed immediately.
      if (state_r == S_IDLE) begin
        pending_r <= 1'b0;
      end else if (new_req_s && !pending_r) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if ((state_r != S_IDLE) && new_req_s && pending_r) begin
        req_drop_r <= 1'b1;
      end else begin
        req_drop_r <= req_drop_r;
      end
      if (abort_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  // Sample capture and block averaging, done on the spi_done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid_r <= 1'b0;
      sample_data_r  <= '0;
      avg_valid_r    <= 1'b0;
      avg_data_r     <= '0;
      acc_r          <= '0;
      idx_r          <= '0;
    end else begin
      sample_valid_r <= capture_s;
      avg_valid_r    <= capture_s && (idx_r == IDX_LAST);
      if (capture_s) begin
        sample_data_r <= spi_data;
        if (idx_r == IDX_LAST) begin
          avg_data_r <= DATA_W'(sum_s >> AVG_LOG2);
          acc_r      <= '0;
          idx_r      <= '0;
        end else begin
          acc_r <= sum_s;
          idx_r <= idx_r + 1'b1;
        end
      end else begin
        sample_data_r <= sample_data_r;
        avg_data_r    <= avg_data_r;
        acc_r         <= acc_r;
        idx_r         <= idx_r;
      end
    end
  end

  assign spi_start    = spi_start_r;
  assign sample_valid = sample_valid_r;
  assign sample_data  = sample_data_r;
  assign avg_valid    = avg_valid_r;
  assign avg_data     = avg_data_r;
  assign timeout_err  = timeout_err_r;
  assign req_drop     = req_drop_r;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: behavioural SPI ADC model plus a sample and
// average scoreboard fed from the values the model returns.
module tb_adc_sample_scheduler;

  localparam int PERIOD   = 200;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int DATA_W   = 8;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auto_en = 1'b0;
  logic        manual_req = 1'b0;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_data = 8'h00;
  logic        spi_start;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic        avg_valid;
  logic [7:0]  avg_data;
  logic        timeout_err;
  logic        req_drop;

  adc_sample_scheduler #(
    .PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .manual_req(manual_req),
    .spi_start(spi_start), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_data(spi_data), .sample_valid(sample_valid), .sample_data(sample_data),
    .avg_valid(avg_valid), .avg_data(avg_data), .timeout_err(timeout_err),
    .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy_mode = 1'b1;
  logic [7:0] data_q[$];
  logic [7:0] exp_q[$];
  int acc_q[$];
  int rise_q[$];
  int done_cyc = 0;
  int starts = 0;
  int last_rise = 0;
  int busy_fall_cyc = 0;
  int n_samples = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI ADC model: responds to spi_start with busy, a 16-cycle transfer and a done pulse.
  initial begin : spi_model
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (busy_mode && spi_start && !rst) begin
        if (data_q.size() > 0) v = data_q.pop_front();
        else v = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        spi_busy = 1'b1;
        repeat (16) @(negedge clk);
        spi_data = v;
        spi_done = 1'b1;
        done_cyc = cyc;
        exp_q.push_back(v);
        @(negedge clk);
        spi_done = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        spi_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every sample must match the model, every NAVG-th carries the average.
  initial begin : monitor
    logic [7:0] v;
    logic start_prev;
    logic busy_prev;
    int sum;
    start_prev = 1'b0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (spi_start && !start_prev) begin
          starts++;
          last_rise = cyc;
          rise_q.push_back(cyc);
        end
        if (!spi_busy && busy_prev) busy_fall_cyc = cyc;
        if (sample_valid || avg_valid) begin
          check("avg_needs_sample", 32'(sample_valid), 32'd1);
          check("sample_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            n_samples++;
            check("sample_data", 32'(sample_data), 32'(v));
            check("sample_latency", 32'(cyc), 32'(done_cyc + 1));
            acc_q.push_back(int'(v));
            if (acc_q.size() == NAVG) begin
              sum = 0;
              foreach (acc_q[i]) sum += acc_q[i];
              check("avg_valid", 32'(avg_valid), 32'd1);
              check("avg_data", 32'(avg_data), 32'(sum >> AVG_LOG2));
              acc_q.delete();
            end else begin
              check("avg_valid_early", 32'(avg_valid), 32'd0);
            end
          end
        end
      end
      start_prev = spi_start;
      busy_prev = spi_busy;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_sample_data"}, 32'(sample_data), 32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_avg_data"}, 32'(avg_data), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_req_drop"}, 32'(req_drop), 32'd0);
  endtask

  task automatic pulse_manual();
    @(negedge clk) manual_req = 1'b1;
    @(negedge clk) manual_req = 1'b0;
  endtask

  task automatic wait_samples(input int target, input int budget);
    int k = 0;
    while (n_samples < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_samples", 32'(n_samples >= target), 32'd1);
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int k = 0;
    while (spi_busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_busy", 32'(spi_busy), 32'(lvl));
  endtask

  task automatic conv();
    int target;
    target = n_samples + 1;
    pulse_manual();
    wait_samples(target, 200);
    repeat (8) @(negedge clk);
  endtask

  initial begin : main
    int n0;
    int s0;
    int k;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // First conversion: spi_start one cycle after the request.
    data_q.push_back(8'h93); data_q.push_back(8'h15);
    data_q.push_back(8'hB4); data_q.push_back(8'h10);
    pulse_manual();
    check("start_latency", 32'(spi_start), 32'd1);
    wait_samples(1, 200);
    repeat (8) @(negedge clk);
    check("first_sample", 32'(sample_data), 32'h93);
    repeat (3) conv();
    check("avg_5b", 32'(avg_data), 32'h5B);

    // Periodic ticks: 1000 enabled cycles give five conversions 200 apart.
    rise_q.delete();
    @(negedge clk) auto_en = 1'b1;
    repeat (1000) @(negedge clk);
    auto_en = 1'b0;
    repeat (100) @(negedge clk);
    check("auto_count", 32'(rise_q.size()), 32'd5);
    for (int i = 1; i < rise_q.size(); i++)
      check("auto_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(PERIOD));

    // Request during WAIT_DONE is held and served after busy falls.
    n0 = starts;
    s0 = n_samples;
    pulse_manual();
    wait_busy(1'b1, 20);
    repeat (3) @(negedge clk);
    pulse_manual();
    k = 0;
    while (starts < n0 + 2 && k < 200) begin @(negedge clk); k++; end
    check("pend_started", 32'(starts), 32'(n0 + 2));
    check("pend_after_busy", 32'(last_rise > busy_fall_cyc), 32'd1);
    check("pend_no_drop", 32'(req_drop), 32'd0);
    wait_samples(s0 + 2, 200);
    repeat (10) @(negedge clk);

    // Two extra requests in one conversion: one served, one dropped.
    n0 = starts;
    s0 = n_samples;
    pulse_manual();
    wait_busy(1'b1, 20);
    repeat (2) @(negedge clk);
    pulse_manual();
    repeat (2) @(negedge clk);
    pulse_manual();
    wait_samples(s0 + 2, 300);
    repeat (40) @(negedge clk);
    check("drop_starts", 32'(starts), 32'(n0 + 2));
    check("drop_flag", 32'(req_drop), 32'd1);

    // Stalled master: abort after TIMEOUT cycles, no sample produced.
    busy_mode = 1'b0;
    s0 = n_samples;
    pulse_manual();
    k = 0;
    while (!timeout_err && k < 300) begin @(negedge clk); k++; end
    check("timeout_cycles", 32'(cyc - last_rise), 32'(TIMEOUT));
    check("timeout_start_low", 32'(spi_start), 32'd0);
    repeat (5) @(negedge clk);
    check("timeout_no_sample", 32'(n_samples), 32'(s0));
    busy_mode = 1'b1;
    repeat (5) conv();

    // Reset mid-transfer, then a clean block of known samples.
    pulse_manual();
    wait_busy(1'b1, 20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    wait_busy(1'b0, 60);
    repeat (3) @(negedge clk);
    exp_q.delete();
    acc_q.delete();
    data_q.push_back(8'd10); data_q.push_back(8'd20);
    data_q.push_back(8'd30); data_q.push_back(8'd40);
    repeat (4) conv();
    check("avg_post_rst", 32'(avg_data), 32'd25);

    // Randomized spacing and data.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      conv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
